// File: rtl/instruction_fetch_rom.sv
// Loadable instruction store: 1-cycle registered read feeding a 2-entry response FIFO.
// Optional per-word even parity enabled by defining INSTRUCTION_ROM_PARITY_EN.
module instruction_fetch_rom #(
   parameter int DATA_WIDTH       = 16,
   parameter int ADDR_WIDTH       = 9,
   parameter int FETCH_ADDR_WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        ReqValid,
   output logic                        ReqReady,
   input  logic [FETCH_ADDR_WIDTH-1:0] ReqAddress,
   output logic                        RespValid,
   input  logic                        RespReady,
   output logic [DATA_WIDTH-1:0]       RespInstruction,
   output logic [FETCH_ADDR_WIDTH-1:0] RespAddress,
   output logic                        RespOutOfRange,
   input  logic                        LoadEn,
   input  logic [ADDR_WIDTH-1:0]       LoadAddress,
   input  logic [DATA_WIDTH-1:0]       LoadData,
   input  logic                        Flush
`ifdef INSTRUCTION_ROM_PARITY_EN
   ,
   output logic                        RespParityErr
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
`ifdef INSTRUCTION_ROM_PARITY_EN
   localparam int MEM_WIDTH = DATA_WIDTH + 1;
`else
   localparam int MEM_WIDTH = DATA_WIDTH;
`endif

   logic [MEM_WIDTH-1:0]        mem_q [DEPTH];
   logic [MEM_WIDTH-1:0]        buf_word_q [2];
   logic [FETCH_ADDR_WIDTH-1:0] buf_addr_q [2];
   logic                        buf_oor_q  [2];

   logic [1:0] count_q, count_d;
   logic       rd_ptr_q, rd_ptr_d;
   logic       wr_ptr_q, wr_ptr_d;
   logic       push, pop, req_oor, resp_valid;
   logic [ADDR_WIDTH-1:0] req_idx;
   logic [MEM_WIDTH-1:0]  load_word;

   assign req_idx = ReqAddress[ADDR_WIDTH-1:0];

   generate
      if (FETCH_ADDR_WIDTH > ADDR_WIDTH) begin : g_oor
         assign req_oor = (ReqAddress[FETCH_ADDR_WIDTH-1:ADDR_WIDTH] != '0);
      end else begin : g_no_oor
         assign req_oor = 1'b0;
      end
   endgenerate

`ifdef INSTRUCTION_ROM_PARITY_EN
   // Stored bit makes the total number of ones in the word even.
   assign load_word = {^LoadData, LoadData};
`else
   assign load_word = LoadData;
`endif

   // ReqReady depends only on occupancy so decode backpressure never reaches fetch combinationally.
   assign ReqReady = (count_q < 2'd2);

   always_comb begin
      push     = ReqValid && ReqReady && !Flush;
      pop      = (count_q != 2'd0) && RespReady && !Flush;
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (Flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (push) wr_ptr_d = ~wr_ptr_q;
         if (pop)  rd_ptr_d = ~rd_ptr_q;
         if (push && !pop)      count_d = count_q + 2'd1;
         else if (pop && !push) count_d = count_q - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   // Both writes are non-blocking, so a same-index load and read returns the old word.
   always_ff @(posedge clk) begin
      if (LoadEn) mem_q[LoadAddress] <= load_word;
   end

   always_ff @(posedge clk) begin
      if (push) begin
         buf_word_q[wr_ptr_q] <= req_oor ? '0 : mem_q[req_idx];
         buf_addr_q[wr_ptr_q] <= ReqAddress;
         buf_oor_q[wr_ptr_q]  <= req_oor;
      end
   end

   assign resp_valid      = (count_q != 2'd0);
   assign RespValid       = resp_valid;
   assign RespInstruction = resp_valid ? buf_word_q[rd_ptr_q][DATA_WIDTH-1:0] : '0;
   assign RespAddress     = resp_valid ? buf_addr_q[rd_ptr_q] : '0;
   assign RespOutOfRange  = resp_valid ? buf_oor_q[rd_ptr_q] : 1'b0;

`ifdef INSTRUCTION_ROM_PARITY_EN
   assign RespParityErr = resp_valid && !buf_oor_q[rd_ptr_q] &&
                          ((^buf_word_q[rd_ptr_q][DATA_WIDTH-1:0]) != buf_word_q[rd_ptr_q][DATA_WIDTH]);
`endif

endmodule

// File: tb/tb_instruction_fetch_rom.sv
// Directed plus random stimulus for instruction_fetch_rom, checked against a queue-based model.
// Define INSTRUCTION_ROM_PARITY_EN to also exercise the parity error path.
module tb_instruction_fetch_rom;
   localparam int DW = 16, AW = 9, FAW = 16, DEPTH = 512;

   logic clk = 1'b0, rst_n = 1'b1;
   logic ReqValid = 0, RespReady = 0, LoadEn = 0, Flush = 0;
   logic ReqReady, RespValid, RespOutOfRange;
   logic [FAW-1:0] ReqAddress = '0, RespAddress;
   logic [DW-1:0]  RespInstruction, LoadData = '0;
   logic [AW-1:0]  LoadAddress = '0;
   logic resp_perr;

   always #5 clk = ~clk;

   instruction_fetch_rom #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FETCH_ADDR_WIDTH(FAW)) dut (
      .clk(clk), .rst_n(rst_n),
`ifdef INSTRUCTION_ROM_PARITY_EN
      .RespParityErr(resp_perr),
`endif
      .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqAddress(ReqAddress),
      .RespValid(RespValid), .RespReady(RespReady), .RespInstruction(RespInstruction),
      .RespAddress(RespAddress), .RespOutOfRange(RespOutOfRange),
      .LoadEn(LoadEn), .LoadAddress(LoadAddress), .LoadData(LoadData), .Flush(Flush));

`ifndef INSTRUCTION_ROM_PARITY_EN
   assign resp_perr = 1'b0;
`endif

   typedef struct {
      logic [DW-1:0]  data;
      logic [FAW-1:0] addr;
      logic           oor;
      logic           perr;
   } resp_t;

   resp_t          exp_q[$];
   logic [DW-1:0]  mem_m [DEPTH];
   bit             par_bad [DEPTH];
   int             tests = 0, fails = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Checks outputs mid-cycle, then advances the model across the next rising edge.
   task automatic tick();
      resp_t n;
      logic  acc, pop;
      logic [AW-1:0] idx;
      @(negedge clk);
      chk("req_ready", ReqReady, exp_q.size() < 2);
      chk("resp_valid", RespValid, exp_q.size() > 0);
      if (exp_q.size() > 0) begin
         chk("resp_data", RespInstruction, exp_q[0].data);
         chk("resp_addr", RespAddress, exp_q[0].addr);
         chk("resp_oor", RespOutOfRange, exp_q[0].oor);
         chk("resp_perr", resp_perr, exp_q[0].perr);
      end else begin
         chk("idle_data", RespInstruction, 0);
         chk("idle_addr", RespAddress, 0);
         chk("idle_oor", RespOutOfRange, 0);
         chk("idle_perr", resp_perr, 0);
      end
      acc    = ReqValid && (exp_q.size() < 2);
      pop    = (exp_q.size() > 0) && RespReady;
      idx    = ReqAddress[AW-1:0];
      n.oor  = (ReqAddress >= FAW'(DEPTH));
      n.data = n.oor ? '0 : mem_m[idx];
      n.addr = ReqAddress;
      n.perr = !n.oor && par_bad[idx];
      if (Flush) begin
         exp_q.delete();
      end else begin
         if (pop) begin
            $display("[TB] resp addr=0x%04h data=0x%04h oor=%0b", exp_q[0].addr, exp_q[0].data, exp_q[0].oor);
            void'(exp_q.pop_front());
         end
         if (acc) exp_q.push_back(n);
      end
      if (LoadEn) begin
         mem_m[LoadAddress]   = LoadData;
         par_bad[LoadAddress] = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
      LoadEn = 1; LoadAddress = a; LoadData = d;
      tick();
      LoadEn = 0;
   endtask

   task automatic request(input logic [FAW-1:0] a);
      ReqValid = 1; ReqAddress = a;
      tick();
      ReqValid = 0;
   endtask

   initial begin
      // Reset: asynchronous assertion away from any edge.
      #2 rst_n = 0;
      #1;
      chk("rst_valid", RespValid, 0);
      chk("rst_data", RespInstruction, 0);
      chk("rst_addr", RespAddress, 0);
      chk("rst_oor", RespOutOfRange, 0);
      chk("rst_perr", resp_perr, 0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1;
      chk("rst_ready", ReqReady, 1);

      for (int i = 0; i < DEPTH; i++) load(AW'(i), DW'($urandom));

      // Back-to-back fetches at both ends of the array.
      load(9'h000, 16'h1234);
      load(9'h1FF, 16'hBEEF);
      RespReady = 1;
      ReqValid = 1; ReqAddress = 16'h0000; tick();
      chk("b2b_first", RespInstruction, 16'h1234);
      ReqAddress = 16'h01FF; tick();
      ReqValid = 0;
      chk("b2b_second", RespInstruction, 16'hBEEF);
      chk("b2b_oor", RespOutOfRange, 0);
      tick();

      request(16'h0200);
      chk("oor_data", RespInstruction, 16'h0000);
      chk("oor_flag", RespOutOfRange, 1);
      chk("oor_addr", RespAddress, 16'h0200);
      tick();

      // Backpressure: third request waits until a slot frees.
      RespReady = 0;
      ReqValid = 1; ReqAddress = 16'h0010; tick();
      ReqAddress = 16'h0011; tick();
      ReqAddress = 16'h0012; tick(); tick();
      chk("full_ready", ReqReady, 0);
      RespReady = 1;
      tick(); tick();
      ReqValid = 0;
      tick(); tick();

      // Load and fetch of the same index in one cycle.
      load(9'h005, 16'h5555);
      LoadEn = 1; LoadAddress = 9'h005; LoadData = 16'hAAAA;
      ReqValid = 1; ReqAddress = 16'h0005;
      tick();
      LoadEn = 0; ReqValid = 0;
      chk("rbw_old", RespInstruction, 16'h5555);
      request(16'h0005);
      chk("rbw_new", RespInstruction, 16'hAAAA);
      tick();

      // Flush while full, alongside a pop and a new request.
      RespReady = 0;
      ReqValid = 1; ReqAddress = 16'h0020; tick();
      ReqAddress = 16'h0021; tick();
      Flush = 1; RespReady = 1; ReqAddress = 16'h0022; tick();
      Flush = 0; ReqValid = 0;
      chk("flush_valid", RespValid, 0);
      chk("flush_ready", ReqReady, 1);
      tick();
      request(16'h0030);
      chk("post_flush", RespInstruction, mem_m[9'h030]);
      tick();

`ifdef INSTRUCTION_ROM_PARITY_EN
      load(9'h003, 16'h00FF);
      dut.mem_q[3][DW] = ~dut.mem_q[3][DW];
      par_bad[3] = 1'b1;
      request(16'h0003);
      chk("parity_bad", resp_perr, 1);
      request(16'h0000);
      chk("parity_clean", resp_perr, 0);
      tick();
`endif

      for (int i = 0; i < 1500; i++) begin
         int hi;
         ReqValid  = ($urandom_range(0, 9) < 7);
         RespReady = ($urandom_range(0, 9) < 7);
         Flush     = ($urandom_range(0, 99) < 3);
         LoadEn    = ($urandom_range(0, 9) < 2);
         LoadAddress = AW'($urandom);
         LoadData    = DW'($urandom);
         hi = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 127)) : 0;
         ReqAddress = FAW'(hi * DEPTH + int'($urandom_range(0, DEPTH - 1)));
         tick();
      end
      ReqValid = 0; LoadEn = 0; Flush = 0; RespReady = 0;

      // Reset in the middle of a full buffer.
      ReqValid = 1; ReqAddress = 16'h0040; tick(); tick();
      ReqValid = 0;
      #1 rst_n = 0;
      #1;
      chk("midrst_valid", RespValid, 0);
      chk("midrst_ready", ReqReady, 1);
      exp_q.delete();
      #1 rst_n = 1;
      RespReady = 1;
      request(16'h0041);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
